// File: rtl/vco_adc_scheduler.sv
// vco_adc_scheduler: steps through the enabled VCO channels, integrates each
// channel's phase counter over a window and queues {channel, count delta}
// results in a small FIFO for a ready/valid consumer.
module vco_adc_scheduler #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          start_i,
  input  logic                          cont_i,
  input  logic [2:0]                    ch_mask_i,
  input  logic [7:0]                    settle_i,
  input  logic [15:0]                   window_i,
  input  logic [CNT_W-1:0]              vco_cnt0_i,
  input  logic [CNT_W-1:0]              vco_cnt1_i,
  input  logic [CNT_W-1:0]              vco_cnt2_i,
  output logic [2:0]                    vco_en_o,
  output logic                          busy_o,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic [CNT_W-1:0]              res_data_o,
  output logic [1:0]                    res_ch_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LVL_W = AW + 1;

  typedef enum logic [1:0] {IDLE, SETTLE, INTEG, STORE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        mask_q;
  logic [7:0]        settle_q;
  logic [15:0]       window_q;
  logic [1:0]        ch_q, ch_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       settle_lim, window_lim;
  logic [CNT_W-1:0]  snap_q, result_q, vco_sel;
  logic              load_cfg, load_snap, load_result;
  logic [2:0]        nxt_ch;

  logic [CNT_W+1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [LVL_W-1:0]  level_q;
  logic              overflow_q;
  logic              push, pop, full, push_ok, drop;

  // Lowest enabled channel of a mask (mask is known to be non-zero).
  function automatic logic [1:0] lowest_ch(input logic [2:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  // Next enabled channel strictly above c, returned as {found, channel}.
  function automatic logic [2:0] next_ch(input logic [2:0] m, input logic [1:0] c);
    logic [2:0] r;
    r = 3'b000;
    case (c)
      2'd0: begin
        if (m[1])      r = 3'b101;
        else if (m[2]) r = 3'b110;
      end
      2'd1: if (m[2]) r = 3'b110;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  assign nxt_ch = next_ch(mask_q, ch_q);

  // Zero settle/window lengths behave as one cycle.
  always_comb begin
    settle_lim = (settle_q == 8'd0)  ? 16'd0 : {8'd0, settle_q} - 16'd1;
    window_lim = (window_q == 16'd0) ? 16'd0 : window_q - 16'd1;
  end

  // Counter of the currently selected channel.
  always_comb begin
    case (ch_q)
      2'd1:    vco_sel = vco_cnt1_i;
      2'd2:    vco_sel = vco_cnt2_i;
      default: vco_sel = vco_cnt0_i;
    endcase
  end

  // Next-state logic: scan sequencing through settle, integrate and store.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    cnt_d       = cnt_q;
    load_cfg    = 1'b0;
    load_snap   = 1'b0;
    load_result = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && (ch_mask_i != 3'b000)) begin
          load_cfg = 1'b1;
          ch_d     = lowest_ch(ch_mask_i);
          cnt_d    = 16'd0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == settle_lim) begin
          load_snap = 1'b1;
          cnt_d     = 16'd0;
          state_d   = INTEG;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      INTEG: begin
        if (cnt_q == window_lim) begin
          load_result = 1'b1;
          cnt_d       = 16'd0;
          state_d     = STORE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STORE: begin
        cnt_d = 16'd0;
        if (nxt_ch[2]) begin
          ch_d    = nxt_ch[1:0];
          state_d = SETTLE;
        end else if (cont_i) begin
          ch_d    = lowest_ch(mask_q);
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched configuration, snapshot and wrap-safe result registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      mask_q   <= 3'b000;
      settle_q <= 8'd0;
      window_q <= 16'd0;
      ch_q     <= 2'd0;
      cnt_q    <= 16'd0;
      snap_q   <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      if (load_cfg) begin
        mask_q   <= ch_mask_i;
        settle_q <= settle_i;
        window_q <= window_i;
      end
      if (load_snap)   snap_q   <= vco_sel;
      if (load_result) result_q <= vco_sel - snap_q;
    end
  end

  // A full FIFO still accepts a push when the same cycle pops.
  always_comb begin
    push    = (state_q == STORE);
    pop     = res_valid_o & res_ready_i;
    full    = (level_q == LVL_W'(FIFO_DEPTH));
    push_ok = push & (~full | pop);
    drop    = push & full & ~pop;
  end

  // Result FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= {ch_q, result_q};
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Outputs decoded from state and FIFO registers only.
  always_comb begin
    vco_en_o     = ((state_q == SETTLE) || (state_q == INTEG)) ? (3'b001 << ch_q) : 3'b000;
    busy_o       = (state_q != IDLE);
    res_valid_o  = (level_q != '0);
    {res_ch_o, res_data_o} = mem_q[rd_q];
    fifo_level_o = level_q;
    overflow_o   = overflow_q;
  end

endmodule
